tpu_tile_sequencer: RTL



---
 rtl/tpu_pkg.sv | 18 +
 rtl/valid_delay_line.sv | 24 ++
 rtl/tpu_tile_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared constants for the TPU tile sequencer:
// FSM state encoding and the default systolic-array latency.
package tpu_pkg;

   localparam int MATRIX_SIZE = 8;
   localparam int NUM_PE_ROWS = 8;
   // operand skew down the rows plus result drain across the columns
   localparam int SA_LATENCY_DEF = MATRIX_SIZE + NUM_PE_ROWS;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_W_WAIT  = 3'd1;
   localparam logic [2:0] S_W_LOAD  = 3'd2;
   localparam logic [2:0] S_W_LATCH = 3'd3;
   localparam logic [2:0] S_STREAM  = 3'd4;
   localparam logic [2:0] S_DRAIN   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/valid_delay_line.sv
// Single-bit valid shift register with synchronous clear.
// q follows d exactly DEPTH cycles later.
module valid_delay_line
   import tpu_pkg::*;
#(
   parameter int DEPTH = SA_LATENCY_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rstn || clr) sr <= '0;
      else              sr <= {sr[DEPTH-2:0], d};
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: weight FIFO pop, weight reload, UB streaming
// and results-SRAM write addressing over several weight tiles.
module tpu_tile_sequencer
   import tpu_pkg::*;
#(
   parameter int ADDRESSSIZE = 10,
   parameter int VEC_BW      = 8,
   parameter int TILE_BW     = 4,
   parameter int SA_LATENCY  = SA_LATENCY_DEF
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDRESSSIZE-1:0] cfg_in_base,
   input  logic [ADDRESSSIZE-1:0] cfg_out_base,
   input  logic [VEC_BW-1:0]      cfg_num_vec,
   input  logic [TILE_BW-1:0]     cfg_num_tiles,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   we_rl,
   output logic                   ub_re,
   output logic [ADDRESSSIZE-1:0] ub_addr,
   output logic                   res_we,
   output logic [ADDRESSSIZE-1:0] res_addr,
   output logic [TILE_BW-1:0]     tile_idx,
   output logic                   busy,
   output logic                   end_
);

   logic [2:0]             state_q, state_d;
   logic [ADDRESSSIZE-1:0] in_base_q, ub_addr_q, res_addr_q;
   logic [VEC_BW-1:0]      num_vec_q, vec_q;
   logic [TILE_BW-1:0]     num_tiles_q, tile_q;
   logic [VEC_BW:0]        outst_q;
   logic                   last_tile, last_vec, drain_done, adv;

   assign last_tile  = ({1'b0, tile_q} + (TILE_BW+1)'(1))
                       >= {1'b0, num_tiles_q};
   assign last_vec   = vec_q == (num_vec_q - VEC_BW'(1));
   assign drain_done = res_we && (outst_q == (VEC_BW+1)'(1));

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_W_WAIT;
         S_W_WAIT:  if (!fifo_empty) state_d = S_W_LOAD;
         S_W_LOAD:  state_d = S_W_LATCH;
         S_W_LATCH: begin
            if (num_vec_q != '0) state_d = S_STREAM;
            else state_d = last_tile ? S_DONE : S_W_WAIT;
         end
         S_STREAM:  if (last_vec) state_d = S_DRAIN;
         S_DRAIN: begin
            if (drain_done)
               state_d = last_tile ? S_DONE : S_W_WAIT;
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_comb begin
      fifo_read_enable = 1'b0;
      we_rl            = 1'b0;
      ub_re            = 1'b0;
      end_             = 1'b0;
      busy             = 1'b1;
      unique case (state_q)
         S_IDLE:    busy = 1'b0;
         S_W_LOAD:  fifo_read_enable = 1'b1;
         S_W_LATCH: we_rl = 1'b1;
         S_STREAM:  ub_re = 1'b1;
         S_DONE:    end_ = 1'b1;
         default:   ;
      endcase
   end

   assign adv = (state_d == S_W_WAIT) &&
                ((state_q == S_W_LATCH) || (state_q == S_DRAIN));

   always_ff @(posedge clk) begin
      if (!rstn || abort) begin
         in_base_q   <= '0;
         num_vec_q   <= '0;
         num_tiles_q <= '0;
         vec_q       <= '0;
         tile_q      <= '0;
         outst_q     <= '0;
         ub_addr_q   <= '0;
         res_addr_q  <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            in_base_q   <= cfg_in_base;
            num_vec_q   <= cfg_num_vec;
            num_tiles_q <= (cfg_num_tiles == '0) ? TILE_BW'(1)
                                                 : cfg_num_tiles;
            tile_q      <= '0;
            outst_q     <= '0;
            res_addr_q  <= cfg_out_base;
         end
         if (state_q == S_W_LATCH) begin
            vec_q     <= '0;
            ub_addr_q <= in_base_q;
         end
         if (ub_re) begin
            vec_q     <= vec_q + VEC_BW'(1);
            ub_addr_q <= ub_addr_q + ADDRESSSIZE'(1);
         end
         if (res_we) res_addr_q <= res_addr_q + ADDRESSSIZE'(1);
         if (adv) tile_q <= tile_q + TILE_BW'(1);
         // simultaneous issue and retire leave the count unchanged
         unique case ({ub_re, res_we})
            2'b10:   outst_q <= outst_q + (VEC_BW+1)'(1);
            2'b01:   outst_q <= outst_q - (VEC_BW+1)'(1);
            default: ;
         endcase
      end
   end

   valid_delay_line #(
      .DEPTH (SA_LATENCY)
   ) u_dly (
      .clk  (clk),
      .rstn (rstn),
      .clr  (abort),
      .d    (ub_re),
      .q    (res_we)
   );

   assign ub_addr  = ub_addr_q;
   assign res_addr = res_addr_q;
   assign tile_idx = tile_q;

endmodule
